// File: rtl/veri_phase_comp_ctrl.sv
// Loop controller for the 2-bit phase-comparator adder: votes early/late over a
// window, steps the phase select through the external adder, then settles.
module veri_phase_comp_ctrl #(
  parameter int WIN_LEN  = 8,
  parameter int THRESH   = 2,
  parameter int HOLDOFF  = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       early,
  input  logic       late,
  input  logic [1:0] sum_in,
  output logic [1:0] adder_in_o,
  output logic       down_o,
  output logic [1:0] phase_sel,
  output logic       step_valid,
  output logic       sat_hit,
  output logic       locked,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_DECIDE  = 3'd2,
    S_UPDATE  = 3'd3,
    S_SETTLE  = 3'd4
  } state_t;

  localparam int VW = $clog2(WIN_LEN) + 2;
  localparam int WW = $clog2(WIN_LEN) + 1;
  localparam int SW = $clog2(HOLDOFF) + 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(HOLDOFF - 1);
  localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);
  localparam logic signed [VW-1:0] THR_POS = VW'(THRESH);
  localparam logic signed [VW-1:0] THR_NEG = -THR_POS;

  state_t                 state;
  logic signed [VW-1:0]   vote;
  logic signed [VW-1:0]   delta;
  logic [WW-1:0]          win_cnt;
  logic [SW-1:0]          settle_cnt;
  logic [3:0]             quiet_cnt;
  logic [1:0]             sum_cap;

  // Adder interface: adder_in_o/down_o are held stable through UPDATE and the
  // adder's sum_in is sampled on the UPDATE clock edge; there is no back-pressure.
  assign adder_in_o = phase_sel;
  assign state_dbg  = state;
  assign sum_cap    = (sum_in == 2'b11) ? 2'b10 : sum_in;

  always_comb begin
    delta = '0;
    if (early && !late)      delta = VW'(1);
    else if (late && !early) delta = -VW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase_sel  <= 2'b01;
      down_o     <= 1'b0;
      step_valid <= 1'b0;
      sat_hit    <= 1'b0;
      locked     <= 1'b0;
      vote       <= '0;
      win_cnt    <= '0;
      quiet_cnt  <= '0;
      settle_cnt <= '0;
    end else begin
      step_valid <= 1'b0;
      sat_hit    <= 1'b0;
      if (!enable) begin
        state      <= S_IDLE;
        vote       <= '0;
        win_cnt    <= '0;
        quiet_cnt  <= '0;
        settle_cnt <= '0;
        locked     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_COLLECT;
            vote    <= '0;
            win_cnt <= '0;
          end
          S_COLLECT: begin
            vote <= vote + delta;
            if (win_cnt == WIN_LAST) state <= S_DECIDE;
            else win_cnt <= win_cnt + 1'b1;
          end
          S_DECIDE: begin
            if (vote >= THR_POS) begin
              down_o <= 1'b0;
              state  <= S_UPDATE;
            end else if (vote <= THR_NEG) begin
              down_o <= 1'b1;
              state  <= S_UPDATE;
            end else begin
              if (quiet_cnt != LOCK_MAX) quiet_cnt <= quiet_cnt + 4'd1;
              if (quiet_cnt >= LOCK_MAX - 4'd1) locked <= 1'b1;
              state   <= S_COLLECT;
              vote    <= '0;
              win_cnt <= '0;
            end
          end
          S_UPDATE: begin
            phase_sel <= sum_cap;
            // An unchanged sum means the adder saturated at a range end.
            if (sum_cap != phase_sel) begin
              step_valid <= 1'b1;
              locked     <= 1'b0;
            end else begin
              sat_hit <= 1'b1;
            end
            quiet_cnt  <= '0;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
          S_SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              state   <= S_COLLECT;
              vote    <= '0;
              win_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_veri_phase_comp_ctrl.sv
// Directed bench for veri_phase_comp_ctrl with a saturating 2-bit adder model
// closing the loop; every expected value is hand-derived cycle by cycle.
module tb_veri_phase_comp_ctrl;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_DECIDE  = 3'd2;
  localparam logic [2:0] ST_UPDATE  = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       early = 1'b0;
  logic       late = 1'b0;
  logic [1:0] sum_in;
  logic [1:0] adder_in_o;
  logic       down_o;
  logic [1:0] phase_sel;
  logic       step_valid;
  logic       sat_hit;
  logic       locked;
  logic [2:0] state_dbg;

  logic       sum_force = 1'b0;
  logic [1:0] sum_val = 2'b00;

  int checks = 0;
  int failures = 0;

  veri_phase_comp_ctrl #(
    .WIN_LEN(8), .THRESH(2), .HOLDOFF(4), .LOCK_CNT(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .early(early), .late(late),
    .sum_in(sum_in), .adder_in_o(adder_in_o), .down_o(down_o),
    .phase_sel(phase_sel), .step_valid(step_valid), .sat_hit(sat_hit),
    .locked(locked), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // saturating phase adder model, with an override to inject raw sums
  always_comb begin
    if (sum_force)   sum_in = sum_val;
    else if (down_o) sum_in = (adder_in_o == 2'd0) ? 2'd0 : adder_in_o - 2'd1;
    else             sum_in = (adder_in_o >= 2'd2) ? 2'd2 : adder_in_o + 2'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_window(input logic [7:0] e_pat, input logic [7:0] l_pat);
    for (int i = 0; i < 8; i++) begin
      early = e_pat[i];
      late  = l_pat[i];
      tick(1);
    end
    early = 1'b0;
    late  = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_phase", phase_sel, 2'd1);
    check("rst_adder_in", adder_in_o, 2'd1);
    check("rst_down", down_o, 1'b0);
    check("rst_step", step_valid, 1'b0);
    check("rst_sat", sat_hit, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    tick(1);

    // constant early: step 1->2 after 8 samples + DECIDE + UPDATE
    enable = 1'b1;
    early  = 1'b1;
    tick(1);
    check("up_collect", state_dbg, ST_COLLECT);
    tick(8);
    check("up_decide", state_dbg, ST_DECIDE);
    tick(1);
    check("up_update", state_dbg, ST_UPDATE);
    check("up_phase_hold", phase_sel, 2'd1);
    check("up_down", down_o, 1'b0);
    tick(1);
    check("up_phase", phase_sel, 2'd2);
    check("up_step", step_valid, 1'b1);
    check("up_settle", state_dbg, ST_SETTLE);
    check("up_adder_in", adder_in_o, 2'd2);
    tick(1);
    check("up_step_pulse", step_valid, 1'b0);
    tick(12);
    check("up2_update", state_dbg, ST_UPDATE);
    tick(1);
    check("up2_sat", sat_hit, 1'b1);
    check("up2_step", step_valid, 1'b0);
    check("up2_phase", phase_sel, 2'd2);
    check("up2_down", down_o, 1'b0);
    tick(1);
    check("up2_sat_pulse", sat_hit, 1'b0);

    // constant late: 2->1->0 every 14 cycles, then saturate at 0
    early = 1'b0;
    late  = 1'b1;
    tick(13);
    check("dn1_phase", phase_sel, 2'd1);
    check("dn1_step", step_valid, 1'b1);
    check("dn1_down", down_o, 1'b1);
    tick(14);
    check("dn2_phase", phase_sel, 2'd0);
    check("dn2_step", step_valid, 1'b1);
    tick(14);
    check("dn3_sat", sat_hit, 1'b1);
    check("dn3_phase", phase_sel, 2'd0);
    check("dn3_down", down_o, 1'b1);
    check("dn3_locked", locked, 1'b0);

    // early=late=1: three quiet windows assert locked
    early = 1'b1;
    late  = 1'b1;
    tick(30);
    check("q3_decide", state_dbg, ST_DECIDE);
    check("q3_not_yet", locked, 1'b0);
    tick(1);
    check("q3_locked", locked, 1'b1);
    check("q3_collect", state_dbg, ST_COLLECT);

    // alternating early/late: another quiet window, lock held
    for (int i = 0; i < 9; i++) begin
      early = i[0];
      late  = ~i[0];
      tick(1);
    end
    check("alt_locked", locked, 1'b1);
    check("alt_collect", state_dbg, ST_COLLECT);
    check("alt_phase", phase_sel, 2'd0);

    // sat_hit while locked keeps lock; the next real step drops it
    early = 1'b0;
    late  = 1'b1;
    tick(10);
    check("lk_sat", sat_hit, 1'b1);
    check("lk_sat_locked", locked, 1'b1);
    early = 1'b1;
    late  = 1'b0;
    tick(14);
    check("lk_step_phase", phase_sel, 2'd1);
    check("lk_step", step_valid, 1'b1);
    check("lk_drop", locked, 1'b0);

    // vote exactly +THRESH steps; vote +1 is quiet
    early = 1'b0;
    tick(4);
    check("mix_collect", state_dbg, ST_COLLECT);
    drive_window(8'b0001_1111, 8'b1110_0000);
    check("mix52_decide", state_dbg, ST_DECIDE);
    tick(1);
    check("mix52_update", state_dbg, ST_UPDATE);
    tick(1);
    check("mix52_phase", phase_sel, 2'd2);
    tick(4);
    check("mix_collect2", state_dbg, ST_COLLECT);
    drive_window(8'b0000_1111, 8'b0111_0000);
    tick(1);
    check("mix431_quiet", state_dbg, ST_COLLECT);
    check("mix431_phase", phase_sel, 2'd2);
    check("mix431_sat", sat_hit, 1'b0);

    // enable dropped during UPDATE suppresses the capture
    drive_window(8'h00, 8'hff);
    tick(2);
    check("en_pre_phase", phase_sel, 2'd1);
    tick(4);
    drive_window(8'hff, 8'h00);
    tick(1);
    check("en_update", state_dbg, ST_UPDATE);
    enable = 1'b0;
    tick(1);
    check("en_phase", phase_sel, 2'd1);
    check("en_step", step_valid, 1'b0);
    check("en_sat", sat_hit, 1'b0);
    check("en_state", state_dbg, ST_IDLE);
    check("en_locked", locked, 1'b0);

    // raw sum 3 is clamped to 2
    enable = 1'b1;
    early  = 1'b1;
    tick(1);
    check("clamp_collect", state_dbg, ST_COLLECT);
    tick(9);
    sum_force = 1'b1;
    sum_val   = 2'b11;
    tick(1);
    check("clamp_phase", phase_sel, 2'd2);
    check("clamp_step", step_valid, 1'b1);
    sum_force = 1'b0;
    early     = 1'b0;

    // asynchronous reset in SETTLE takes effect without a clock edge
    rst = 1'b1;
    #2;
    check("arst_phase", phase_sel, 2'd1);
    check("arst_step", step_valid, 1'b0);
    check("arst_state", state_dbg, ST_IDLE);
    check("arst_locked", locked, 1'b0);
    #2;
    rst = 1'b0;
    tick(1);
    check("arst_collect", state_dbg, ST_COLLECT);

    // late pulses injected during SETTLE must not reach the next vote
    drive_window(8'hff, 8'h00);
    tick(2);
    check("ign_phase_up", phase_sel, 2'd2);
    late = 1'b1;
    tick(4);
    check("ign_collect", state_dbg, ST_COLLECT);
    drive_window(8'h00, 8'h00);
    tick(1);
    check("ign_quiet", state_dbg, ST_COLLECT);
    check("ign_phase", phase_sel, 2'd2);
    check("ign_step", step_valid, 1'b0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
